// File: rtl/bus_target_7501.sv
// bus_target_7501: 7501 CPU bus target decoding a 2^ADDR_BITS register window.
// phi2/aec/r_w are oversampled by the fast clock. Read data is driven while phi2 is high,
// and write data is captured at phi2 fall. Internal registers are reached through a
// read index and a one-clock write strobe.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   phi2, aec, r_w      asynchronous CPU bus controls
//   address, data_in    CPU address and data (input path)
//   data_out, data_oe   read data and bus driver enable
//   rd_index, rd_data   register read lookup (rd_data valid the clock after rd_index)
//   wr_valid/index/data one-clock register write strobe
//   timeout             one-clock pulse when phi2 never falls within TIMEOUT_CLKS
module bus_target_7501 #(
   parameter logic [15:0] BASE_ADDR    = 16'hFD00,
   parameter int unsigned ADDR_BITS    = 2,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned HOLD_CLKS    = 2,
   parameter int unsigned TIMEOUT_CLKS = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 phi2,
   input  logic                 aec,
   input  logic                 r_w,
   input  logic [15:0]          address,
   input  logic [7:0]           data_in,
   output logic [7:0]           data_out,
   output logic                 data_oe,
   output logic [ADDR_BITS-1:0] rd_index,
   input  logic [7:0]           rd_data,
   output logic                 wr_valid,
   output logic [ADDR_BITS-1:0] wr_index,
   output logic [7:0]           wr_data,
   output logic                 timeout
);

   localparam int unsigned HOLD_W = $clog2(HOLD_CLKS + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CLKS + 1);

   typedef enum logic [2:0] {IDLE, LOOKUP, DRIVE, WAIT_FALL, HOLD} state_t;

   state_t                  state, state_nx;
   logic [SYNC_STAGES-1:0]  phi2_sync, aec_sync, rw_sync;
   logic                    phi2_d;
   logic [7:0]              data_pipe [SYNC_STAGES+1];
   logic [HOLD_W-1:0]       hold_cnt, hold_nx;
   logic [TMO_W-1:0]        tmo_cnt, tmo_nx;

   logic [7:0]              data_out_nx, wr_data_nx;
   logic                    data_oe_nx, wr_valid_nx, timeout_nx;
   logic [ADDR_BITS-1:0]    rd_index_nx, wr_index_nx;

   logic phi2_s, aec_s, rw_s, rise, fall, hit, start, tmo_hit;
   logic [ADDR_BITS-1:0] idx;

   assign phi2_s  = phi2_sync[SYNC_STAGES-1];
   assign aec_s   = aec_sync[SYNC_STAGES-1];
   assign rw_s    = rw_sync[SYNC_STAGES-1];
   assign rise    = phi2_s & ~phi2_d;
   assign fall    = ~phi2_s & phi2_d;
   assign hit     = aec_s & (address[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
   assign idx     = address[ADDR_BITS-1:0];
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

   // Synchronizers; data_in is delayed one extra stage so the value used at the
   // detected fall is the last one sampled while raw phi2 was still high.
   always_ff @(posedge clock) begin
      if (reset) begin
         phi2_sync <= '0;
         aec_sync  <= '0;
         rw_sync   <= '0;
         phi2_d    <= 1'b0;
         for (int i = 0; i <= int'(SYNC_STAGES); i++) data_pipe[i] <= 8'h00;
      end else begin
         phi2_sync <= {phi2_sync[SYNC_STAGES-2:0], phi2};
         aec_sync  <= {aec_sync[SYNC_STAGES-2:0], aec};
         rw_sync   <= {rw_sync[SYNC_STAGES-2:0], r_w};
         phi2_d    <= phi2_s;
         data_pipe[0] <= data_in;
         for (int i = 1; i <= int'(SYNC_STAGES); i++) data_pipe[i] <= data_pipe[i-1];
      end
   end

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
         tmo_cnt  <= '0;
         data_out <= 8'h00;
         data_oe  <= 1'b0;
         rd_index <= '0;
         wr_valid <= 1'b0;
         wr_index <= '0;
         wr_data  <= 8'h00;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nx;
         hold_cnt <= hold_nx;
         tmo_cnt  <= tmo_nx;
         data_out <= data_out_nx;
         data_oe  <= data_oe_nx;
         rd_index <= rd_index_nx;
         wr_valid <= wr_valid_nx;
         wr_index <= wr_index_nx;
         wr_data  <= wr_data_nx;
         timeout  <= timeout_nx;
      end
   end

   // Next state and next output values
   always_comb begin
      state_nx    = state;
      hold_nx     = hold_cnt;
      tmo_nx      = rise ? '0 : tmo_cnt;
      data_out_nx = data_out;
      data_oe_nx  = data_oe;
      rd_index_nx = rd_index;
      wr_valid_nx = 1'b0;
      wr_index_nx = wr_index;
      wr_data_nx  = wr_data;
      timeout_nx  = 1'b0;
      start       = 1'b0;

      case (state)
         IDLE: start = rise & hit;

         LOOKUP: begin
            tmo_nx = tmo_cnt + TMO_W'(1);
            if (tmo_hit) begin
               timeout_nx = 1'b1;
               state_nx   = IDLE;
            end else begin
               data_out_nx = rd_data;
               data_oe_nx  = 1'b1;
               state_nx    = DRIVE;
            end
         end

         DRIVE: begin
            tmo_nx = tmo_cnt + TMO_W'(1);
            if (tmo_hit) begin
               data_oe_nx = 1'b0;
               timeout_nx = 1'b1;
               state_nx   = IDLE;
            end else if (!aec_s) begin
               data_oe_nx = 1'b0;
               state_nx   = IDLE;
            end else if (fall) begin
               hold_nx  = HOLD_W'(HOLD_CLKS - 1);
               state_nx = HOLD;
            end
         end

         WAIT_FALL: begin
            tmo_nx = tmo_cnt + TMO_W'(1);
            if (tmo_hit) begin
               timeout_nx = 1'b1;
               state_nx   = IDLE;
            end else if (fall) begin
               wr_valid_nx = aec_s;
               wr_index_nx = aec_s ? rd_index : wr_index;
               wr_data_nx  = aec_s ? data_pipe[SYNC_STAGES] : wr_data;
               state_nx    = IDLE;
            end
         end

         HOLD: begin
            // A new rise cuts the hold short and is decoded like a rise in IDLE
            if (rise) begin
               data_oe_nx = 1'b0;
               state_nx   = IDLE;
               start      = hit;
            end else if (hold_cnt == '0) begin
               data_oe_nx = 1'b0;
               state_nx   = IDLE;
            end else begin
               hold_nx = hold_cnt - HOLD_W'(1);
            end
         end

         default: state_nx = IDLE;
      endcase

      // Latch index and direction for a decoded cycle; both are fixed from here on
      if (start) begin
         rd_index_nx = idx;
         state_nx    = rw_s ? LOOKUP : WAIT_FALL;
      end
   end

endmodule

// File: tb/tb_bus_target_7501.sv
// tb_bus_target_7501: directed bus cycles; expected events are queued by the stimulus
// and consumed by a monitor that watches data_oe edges, wr_valid and timeout.
module tb_bus_target_7501;

   localparam int EV_RISE = 0;
   localparam int EV_FALL = 1;
   localparam int EV_WR   = 2;
   localparam int EV_TMO  = 3;

   typedef struct {
      int         kind;
      int         cyc;
      logic [7:0] data;
      logic [1:0] idx;
   } ev_t;

   logic        clock = 1'b0;
   logic        reset, phi2, aec, r_w;
   logic [15:0] address;
   logic [7:0]  data_in, data_out, rd_data, wr_data;
   logic        data_oe, wr_valid, timeout;
   logic [1:0]  rd_index, wr_index;
   logic [7:0]  regs [4];

   int  cyc     = 0;
   int  n_tests = 0;
   int  n_fail  = 0;
   bit  mon_en  = 1'b0;
   logic oe_prev = 1'b0;
   ev_t sb [$];

   bus_target_7501 dut (
      .clock    (clock),
      .reset    (reset),
      .phi2     (phi2),
      .aec      (aec),
      .r_w      (r_w),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out),
      .data_oe  (data_oe),
      .rd_index (rd_index),
      .rd_data  (rd_data),
      .wr_valid (wr_valid),
      .wr_index (wr_index),
      .wr_data  (wr_data),
      .timeout  (timeout)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Register file model: value for rd_index available within the following clock
   assign rd_data = regs[rd_index];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int c, input logic [7:0] d, input logic [1:0] i);
      ev_t e;
      e.kind = kind; e.cyc = c; e.data = d; e.idx = i;
      sb.push_back(e);
   endtask

   task automatic check_ev(input int kind, input logic [7:0] d, input logic [1:0] i);
      ev_t e;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL ev_unexpected: got kind=%0d data=%h idx=%0d at cycle %0d, expected no event",
                  kind, d, i, cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.data !== d || e.idx !== i) begin
            n_fail++;
            $display("FAIL ev_match: got kind=%0d cyc=%0d data=%h idx=%0d, expected kind=%0d cyc=%0d data=%h idx=%0d",
                     kind, cyc, d, i, e.kind, e.cyc, e.data, e.idx);
         end
      end
   endtask

   // Monitor: sample away from the active edge, report every observable event
   always @(negedge clock) begin
      if (mon_en) begin
         if (data_oe && !oe_prev) check_ev(EV_RISE, data_out, 2'd0);
         if (!data_oe && oe_prev) check_ev(EV_FALL, 8'h00, 2'd0);
         if (wr_valid)            check_ev(EV_WR, wr_data, wr_index);
         if (timeout)             check_ev(EV_TMO, 8'h00, 2'd0);
      end
      oe_prev = data_oe;
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_data_oe"},  int'(data_oe),  0);
      chk({tag, "_data_out"}, int'(data_out), 0);
      chk({tag, "_wr_valid"}, int'(wr_valid), 0);
      chk({tag, "_wr_index"}, int'(wr_index), 0);
      chk({tag, "_wr_data"},  int'(wr_data),  0);
      chk({tag, "_rd_index"}, int'(rd_index), 0);
      chk({tag, "_timeout"},  int'(timeout),  0);
   endtask

   // Read cycle: oe rises 4 clocks after raw rise (2 sync + 2 latency),
   // falls 3 + HOLD_CLKS clocks after raw fall.
   task automatic bus_read(input logic [15:0] a, input bit expect_hit, input logic [7:0] exp_d);
      int n, m;
      @(negedge clock);
      n = cyc;
      address = a; r_w = 1'b1; phi2 = 1'b1;
      if (expect_hit) push(EV_RISE, n + 4, exp_d, 2'd0);
      wait_neg(8);
      m = cyc;
      phi2 = 1'b0;
      if (expect_hit) push(EV_FALL, m + 5, 8'h00, 2'd0);
      wait_neg(8);
   endtask

   // Write cycle: strobe 3 clocks after raw fall, carrying data present before the fall
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input bit expect_hit,
                            input bit change_after);
      int m;
      @(negedge clock);
      address = a; r_w = 1'b0; data_in = d; phi2 = 1'b1;
      wait_neg(8);
      m = cyc;
      phi2 = 1'b0;
      if (expect_hit) push(EV_WR, m + 3, d, a[1:0]);
      wait_neg(1);
      if (change_after) data_in = 8'hFF;
      wait_neg(7);
   endtask

   task automatic end_test(input string name);
      chk({name, "_events_done"}, sb.size(), 0);
   endtask

   initial begin
      int n;
      regs[0] = 8'h11; regs[1] = 8'hA5; regs[2] = 8'h5A; regs[3] = 8'hC3;
      reset = 1'b1; phi2 = 1'b0; aec = 1'b1; r_w = 1'b1;
      address = 16'h0000; data_in = 8'h00;
      wait_neg(3);
      check_reset_outputs("reset");
      reset = 1'b0;
      mon_en = 1'b1;
      wait_neg(4);

      bus_read(16'hFD01, 1'b1, 8'hA5);           end_test("read_fd01");
      bus_read(16'hFD02, 1'b1, 8'h5A);           end_test("read_fd02");
      bus_write(16'hFD03, 8'h3C, 1'b1, 1'b0);    end_test("write_fd03");
      chk("write_fd03_oe", int'(data_oe), 0);
      bus_write(16'hFD00, 8'h77, 1'b1, 1'b0);    end_test("write_fd00");
      bus_read(16'hFC01, 1'b0, 8'h00);           end_test("miss_read_fc01");
      bus_write(16'hFD10, 8'h99, 1'b0, 1'b0);    end_test("miss_write_fd10");
      bus_write(16'hFD02, 8'h3C, 1'b1, 1'b1);    end_test("write_data_change");

      // aec dropped while driving: oe low 3 clocks after raw aec fall
      @(negedge clock);
      n = cyc;
      address = 16'hFD02; r_w = 1'b1; phi2 = 1'b1;
      push(EV_RISE, n + 4, 8'h5A, 2'd0);
      wait_neg(6);
      aec = 1'b0;
      push(EV_FALL, n + 9, 8'h00, 2'd0);
      wait_neg(2);
      phi2 = 1'b0;
      wait_neg(8);
      aec = 1'b1;
      wait_neg(4);
      end_test("aec_drop_read");

      // Write whose fall is seen with aec low: no strobe
      @(negedge clock);
      address = 16'hFD01; r_w = 1'b0; data_in = 8'h42; phi2 = 1'b1;
      wait_neg(4);
      aec = 1'b0;
      wait_neg(4);
      phi2 = 1'b0;
      wait_neg(8);
      aec = 1'b1;
      wait_neg(4);
      end_test("aec_low_write");

      // phi2 stuck high: abort TIMEOUT_CLKS clocks after entering LOOKUP
      @(negedge clock);
      n = cyc;
      address = 16'hFD01; r_w = 1'b1; phi2 = 1'b1;
      push(EV_RISE, n + 4, 8'hA5, 2'd0);
      push(EV_FALL, n + 258, 8'h00, 2'd0);
      push(EV_TMO,  n + 258, 8'h00, 2'd0);
      wait_neg(300);
      chk("timeout_oe_low", int'(data_oe), 0);
      phi2 = 1'b0;
      wait_neg(8);
      end_test("timeout");

      // Reset while driving: everything back to reset values on the next clock
      @(negedge clock);
      n = cyc;
      address = 16'hFD03; r_w = 1'b1; phi2 = 1'b1;
      push(EV_RISE, n + 4, 8'hC3, 2'd0);
      wait_neg(6);
      reset = 1'b1; phi2 = 1'b0;
      push(EV_FALL, n + 7, 8'h00, 2'd0);
      wait_neg(1);
      check_reset_outputs("mid_reset");
      wait_neg(1);
      reset = 1'b0;
      wait_neg(8);
      end_test("reset_in_drive");

      bus_read(16'hFD03, 1'b1, 8'hC3);           end_test("read_after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
